// File: rtl/instr_feeder.sv
// Program sequencer feeding instruction words and mvi immediates to the mini-processor.
// Optional wait-for-Done watchdog with an ERROR state is enabled by defining FEEDER_TIMEOUT_EN.
module instr_feeder #(
    parameter int DEPTH = 16,
    parameter int AW = 4
`ifdef FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 8
`endif
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Done,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    output logic [7:0]    DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic [AW:0]   PC,
    output logic          Err
);

`ifdef FEEDER_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_EXEC   = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_EXEC   = 3'd2,
        S_FINISH = 3'd3
    } state_t;
`endif

    localparam logic [AW:0]   PC_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   PC_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   PC_TWO  = {{(AW-1){1'b0}}, 2'b10};
    localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    OP_MVI  = 2'b01;

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       mem_r [DEPTH];
    logic [7:0]       cur_word_s;
    logic [AW:0]      pc_adv_s;
    logic [AW:0]      pc_s;
    logic             fin_s;
    logic [7:0]       next_word_s;
    logic [7:0]       next_imm_s;
    logic [AW-1:0]    imm_addr_s;
    logic [7:0]       din_s;
    logic             run_s;
    logic             busy_s;
`ifdef FEEDER_TIMEOUT_EN
    logic [CW-1:0]    wait_cnt_r;
    logic             timeout_s;
    logic             err_r;
    logic             err_s;
`endif

    // Program memory write port; only open while idle so a running program cannot change.
    always_ff @(posedge Clock) begin
        if (state_r == S_IDLE && prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    assign cur_word_s = mem_r[PC[AW-1:0]];
    assign pc_adv_s   = (cur_word_s[7:6] == OP_MVI) ? (PC + PC_TWO) : (PC + PC_ONE);

`ifdef FEEDER_TIMEOUT_EN
    assign timeout_s = (wait_cnt_r == CW'(TIMEOUT - 1));

    // Done watchdog: restarts on every entry into EXEC.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r != S_EXEC) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (!Done) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Next-state, next-PC and sticky Finished logic.
    always_comb begin
        state_s = state_r;
        pc_s    = PC;
        fin_s   = Finished;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    pc_s    = PC_ZERO;
                    fin_s   = (prog_len == PC_ZERO);
                    state_s = (prog_len == PC_ZERO) ? S_FINISH : S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: state_s = S_EXEC;
            S_EXEC: begin
                if (Done) begin
                    pc_s    = pc_adv_s;
                    fin_s   = (pc_adv_s >= prog_len);
                    state_s = (pc_adv_s >= prog_len) ? S_FINISH : S_ISSUE;
`ifdef FEEDER_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_s = S_ERROR;
`endif
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_FINISH: state_s = S_IDLE;
`ifdef FEEDER_TIMEOUT_EN
            S_ERROR: begin
                if (Start) begin
                    pc_s    = PC_ZERO;
                    fin_s   = (prog_len == PC_ZERO);
                    state_s = (prog_len == PC_ZERO) ? S_FINISH : S_ISSUE;
                end else begin
                    state_s = S_ERROR;
                end
            end
`endif
            default: state_s = S_IDLE;
        endcase
    end

    // The immediate sits one word after the mvi and wraps around the memory.
    assign next_word_s = mem_r[pc_s[AW-1:0]];
    assign imm_addr_s  = pc_s[AW-1:0] + A_ONE;
    assign next_imm_s  = mem_r[imm_addr_s];

    // Output values for the state being entered, so the registers line up with it.
    always_comb begin
        din_s  = 8'h00;
        run_s  = 1'b0;
        busy_s = 1'b0;
        case (state_s)
            S_ISSUE: begin
                din_s  = next_word_s;
                run_s  = 1'b1;
                busy_s = 1'b1;
            end
            S_EXEC: begin
                din_s  = (next_word_s[7:6] == OP_MVI) ? next_imm_s : 8'h00;
                busy_s = 1'b1;
            end
            default: begin
                din_s  = 8'h00;
                run_s  = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

`ifdef FEEDER_TIMEOUT_EN
    assign err_s = (state_s == S_ERROR);
    assign Err   = err_r;
`else
    assign Err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            DIN      <= 8'h00;
            Run      <= 1'b0;
            Busy     <= 1'b0;
            Finished <= 1'b0;
            PC       <= PC_ZERO;
`ifdef FEEDER_TIMEOUT_EN
            err_r    <= 1'b0;
`endif
        end else begin
            DIN      <= din_s;
            Run      <= run_s;
            Busy     <= busy_s;
            Finished <= fin_s;
            PC       <= pc_s;
`ifdef FEEDER_TIMEOUT_EN
            err_r    <= err_s;
`endif
        end
    end

endmodule
